// File: rtl/encoder_scan_if.sv
// Request/beat handshake bundle for encoder_scan: a vector stream in, an index stream out.
interface encoder_scan_if #(
    parameter int IN_WIDTH = 5
);
    localparam int W = 1 << IN_WIDTH;

    logic [W-1:0]        i;
    logic                i_valid;
    logic                i_ready;
    logic [IN_WIDTH-1:0] o;
    logic                o_valid;
    logic                o_ready;
    logic                o_last;
    logic                o_none;

    // Producer of vectors / consumer of beats
    modport master (
        output i, i_valid, o_ready,
        input  i_ready, o, o_valid, o_last, o_none
    );

    // The scanner itself
    modport slave (
        input  i, i_valid, o_ready,
        output i_ready, o, o_valid, o_last, o_none
    );
endinterface

// File: rtl/encoder_scan.sv
// encoder_scan: captures a request vector and emits the indices of its active
// bits, lowest first, one per beat. An empty vector yields one o_none beat.
module encoder_scan #(
    parameter int   IN_WIDTH = 5,
    parameter logic ACTIVE   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    encoder_scan_if.slave bus
);
    localparam int W = 1 << IN_WIDTH;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state, state_nxt;
    logic [W-1:0]        vec;        // remaining bits still to be reported
    logic [W-1:0]        norm;       // input vector with ACTIVE folded to 1
    logic                none;       // captured vector was empty
    logic [IN_WIDTH-1:0] idx;
    logic                accept, beat, one_left;

    assign norm     = ACTIVE ? bus.i : ~bus.i;
    assign accept   = bus.i_valid && bus.i_ready;
    assign beat     = bus.o_valid && bus.o_ready;
    // x & (x-1) clears the lowest set bit, so zero result means a single bit is left
    assign one_left = (vec != '0) && ((vec & (vec - W'(1))) == '0);

    assign bus.i_ready = (state == IDLE) && !rst;
    assign bus.o_valid = (state == SCAN);
    assign bus.o       = idx;
    assign bus.o_last  = bus.o_valid && (none || one_left);
    assign bus.o_none  = bus.o_valid && none;

    // Lowest-set-bit priority encoder; yields 0 for an empty vector
    always_comb begin
        idx = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (vec[k]) idx = IN_WIDTH'(k);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: leave IDLE on accept, return after the final beat is taken
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)               state_nxt = SCAN;
            SCAN: if (beat && bus.o_last)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Held vector: loaded on accept, otherwise only ever loses its lowest bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec  <= '0;
            none <= 1'b0;
        end else if (accept) begin
            vec  <= norm;
            none <= ~|norm;
        end else if (beat) begin
            vec <= vec & (vec - W'(1));
            if (bus.o_last) none <= 1'b0;
        end
    end
endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan: table of vectors plus stall, reset and one-hot sweeps.
module tb_encoder_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;        // 0: ACTIVE-high DUT, 1: ACTIVE-low DUT
    logic [31:0] i_d = '0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;

    logic        ov, ir, ol, on;
    logic [4:0]  o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    encoder_scan_if #(.IN_WIDTH(5)) bus_h ();
    encoder_scan_if #(.IN_WIDTH(5)) bus_l ();

    encoder_scan #(.IN_WIDTH(5), .ACTIVE(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
    encoder_scan #(.IN_WIDTH(5), .ACTIVE(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    assign bus_h.i       = i_d;
    assign bus_l.i       = i_d;
    assign bus_h.i_valid = iv & ~sel;
    assign bus_l.i_valid = iv & sel;
    assign bus_h.o_ready = ordy;
    assign bus_l.o_ready = ordy;

    assign ov = sel ? bus_l.o_valid : bus_h.o_valid;
    assign ir = sel ? bus_l.i_ready : bus_h.i_ready;
    assign ol = sel ? bus_l.o_last  : bus_h.o_last;
    assign on = sel ? bus_l.o_none  : bus_h.o_none;
    assign o  = sel ? bus_l.o       : bus_h.o;

    typedef struct {
        logic [31:0] v;
        bit          s;
        int          n;
        int          b0;
        int          b1;
        int          bl;
        bit          none;
    } vec_t;

    vec_t tab[8];

    int bo[64];
    bit bl[64];
    bit bn[64];
    int nb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Offer one vector with o_ready held high and record every beat it produces
    task automatic run_vec(input logic [31:0] v, input bit s);
        @(negedge clk);
        sel = s; i_d = v; iv = 1'b1; ordy = 1'b1;
        #1 chk("i_ready_idle", ir, 1);
        @(negedge clk);
        iv = 1'b1; i_d = 32'hDEAD_BEEF;   // must be ignored while scanning
        #1 chk("latency", ov, 1);
        nb = 0;
        while (ov && nb < 64) begin
            bo[nb] = int'(o); bl[nb] = ol; bn[nb] = on;
            chk("i_ready_scan", ir, 0);
            nb++;
            if (ol) break;
            @(negedge clk); #1;
        end
        iv = 1'b0;
        @(negedge clk); #1;
        chk("o_valid_after", ov, 0);
        chk("i_ready_after", ir, 1);
    endtask

    initial begin
        tab[0] = '{32'h0000_0100, 1'b0, 1,  8, -1,  8, 1'b0};
        tab[1] = '{32'h8000_0005, 1'b0, 3,  0,  2, 31, 1'b0};
        tab[2] = '{32'h0000_0000, 1'b0, 1,  0, -1,  0, 1'b1};
        tab[3] = '{32'hFFFF_FFFF, 1'b1, 1,  0, -1,  0, 1'b1};
        tab[4] = '{32'hFFFF_FFFF, 1'b0, 32, 0,  1, 31, 1'b0};
        tab[5] = '{32'hFFFF_FFFE, 1'b1, 1,  0, -1,  0, 1'b0};
        tab[6] = '{32'h0000_0030, 1'b0, 2,  4,  5,  5, 1'b0};
        tab[7] = '{32'h8000_0000, 1'b0, 1, 31, -1, 31, 1'b0};

        // Reset state
        @(negedge clk); #1;
        chk("rst_o_valid", ov, 0);
        chk("rst_i_ready", ir, 0);
        chk("rst_o", o, 0);
        chk("rst_o_last", ol, 0);
        chk("rst_o_none", on, 0);
        rst = 1'b0;
        #1 chk("i_ready_after_rst", ir, 1);

        // Table-driven vectors
        for (int t = 0; t < 8; t++) begin
            bit order_ok;
            run_vec(tab[t].v, tab[t].s);
            chk("beat_count", nb, tab[t].n);
            chk("first_idx", bo[0], tab[t].b0);
            if (tab[t].n > 1) chk("second_idx", bo[1], tab[t].b1);
            chk("last_idx", (nb > 0) ? bo[nb-1] : -1, tab[t].bl);
            order_ok = 1'b1;
            for (int j = 0; j < nb; j++) begin
                if (bn[j] != tab[t].none) order_ok = 1'b0;
                if (j < nb - 1 && (bl[j] || bo[j+1] <= bo[j])) order_ok = 1'b0;
            end
            chk("beat_flags", order_ok, 1);
        end

        // Back-pressure: o held at 4 for four stalled cycles, junk input ignored
        @(negedge clk);
        sel = 1'b0; i_d = 32'h0000_0030; iv = 1'b1; ordy = 1'b0;
        @(negedge clk);
        i_d = 32'hFFFF_0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("stall_valid", ov, 1);
            chk("stall_o", o, 4);
            chk("stall_last", ol, 0);
            if (c == 3) begin ordy = 1'b1; iv = 1'b0; end
            @(negedge clk);
        end
        #1;
        chk("stall_o2", o, 5);
        chk("stall_last2", ol, 1);
        @(negedge clk); #1;
        chk("stall_done", ov, 0);
        chk("stall_i_ready", ir, 1);

        // Reset during a scan, after beat o=3 is taken
        @(negedge clk);
        i_d = 32'hFFFF_FFFF; iv = 1'b1; ordy = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (o == 5'd3) break;
            @(negedge clk);
        end
        chk("pre_rst_o", o, 3);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_o_valid", ov, 0);
        chk("mid_rst_i_ready", ir, 0);
        @(negedge clk); #1;
        chk("mid_rst_hold", ov, 0);
        rst = 1'b0;
        #1 chk("post_rst_i_ready", ir, 1);
        run_vec(32'h0000_0002, 1'b0);
        chk("post_rst_count", nb, 1);
        chk("post_rst_o", bo[0], 1);
        chk("post_rst_last", bl[0], 1);

        // One-hot sweep through a bench-side decoder, alternating ACTIVE polarity
        for (int k = 0; k < 32; k++) begin
            logic [31:0] onehot;
            bit s;
            s = bit'(k % 2);
            onehot = 32'h1 << k;
            run_vec(s ? ~onehot : onehot, s);
            chk("sweep_count", nb, 1);
            chk("sweep_idx", bo[0], k);
            chk("sweep_last", bl[0], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
